// File: rtl/ej32_rom_arb.sv
// Byte-serial ROM port arbiter: instruction fetch (1 byte) and data load (1/2/4 bytes)
// share one registered ROM address port; load data is assembled big-endian, zero-extended.
module ej32_rom_arb #(
    parameter int ASZ = 17
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           if_req,
    input  logic [ASZ-1:0] if_addr,
    output logic           if_ack,
    output logic [7:0]     if_data,
    input  logic           ld_req,
    input  logic [ASZ-1:0] ld_addr,
    input  logic [1:0]     ld_sz,
    output logic           ld_ack,
    output logic [31:0]    ld_data,
    output logic [ASZ-1:0] rom_a,
    input  logic [7:0]     rom_d,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        LAST = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           last_ld_q, last_ld_d;
    logic           id_ld_q, id_ld_d;
    logic           first_q, first_d;
    logic [1:0]     rem_q, rem_d;
    logic [23:0]    acc_q, acc_d;
    logic [ASZ-1:0] rom_a_q, rom_a_d;
    logic [7:0]     if_data_q, if_data_d;
    logic [31:0]    ld_data_q, ld_data_d;
    logic           grant_ld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_ld_q <= 1'b0;
            id_ld_q   <= 1'b0;
            first_q   <= 1'b0;
            rem_q     <= 2'd0;
            acc_q     <= 24'h0;
            rom_a_q   <= '0;
            if_data_q <= 8'h0;
            ld_data_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            last_ld_q <= last_ld_d;
            id_ld_q   <= id_ld_d;
            first_q   <= first_d;
            rem_q     <= rem_d;
            acc_q     <= acc_d;
            rom_a_q   <= rom_a_d;
            if_data_q <= if_data_d;
            ld_data_q <= ld_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_ld_d = last_ld_q;
        id_ld_d   = id_ld_q;
        first_d   = first_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        rom_a_d   = rom_a_q;
        if_data_d = if_data_q;
        ld_data_d = ld_data_q;
        grant_ld  = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req || ld_req) begin
                    // On a tie the requester that did not win last time is served.
                    grant_ld  = ld_req && (!if_req || !last_ld_q);
                    id_ld_d   = grant_ld;
                    last_ld_d = grant_ld;
                    first_d   = 1'b1;
                    acc_d     = 24'h0;
                    state_d   = RD;
                    if (grant_ld) begin
                        rom_a_d = ld_addr;
                        case (ld_sz)
                            2'b00:   rem_d = 2'd0;
                            2'b01:   rem_d = 2'd1;
                            default: rem_d = 2'd3;
                        endcase
                    end else begin
                        rom_a_d = if_addr;
                        rem_d   = 2'd0;
                    end
                end
            end
            RD: begin
                // rom_d lags rom_a by one cycle, so the first RD cycle has nothing to capture.
                first_d = 1'b0;
                if (!first_q) begin
                    acc_d = {acc_q[15:0], rom_d};
                end
                if (rem_q == 2'd0) begin
                    state_d = LAST;
                end else begin
                    rom_a_d = rom_a_q + ASZ'(1);
                    rem_d   = rem_q - 2'd1;
                end
            end
            LAST: begin
                state_d = DONE;
                if (id_ld_q) begin
                    ld_data_d = {acc_q, rom_d};
                end else begin
                    if_data_d = rom_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign if_ack  = (state_q == DONE) && !id_ld_q;
    assign ld_ack  = (state_q == DONE) && id_ld_q;
    assign if_data = if_data_q;
    assign ld_data = ld_data_q;
    assign rom_a   = rom_a_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ej32_rom_arb.sv
// Self-checking bench for ej32_rom_arb: vector table, arbitration/reset sequences and
// randomized transactions against a byte-array ROM reference model.
module tb_ej32_rom_arb;

    localparam int ASZ   = 17;
    localparam int ROMSZ = 1 << ASZ;

    logic           clk;
    logic           rst;
    logic           if_req;
    logic [ASZ-1:0] if_addr;
    logic           if_ack;
    logic [7:0]     if_data;
    logic           ld_req;
    logic [ASZ-1:0] ld_addr;
    logic [1:0]     ld_sz;
    logic           ld_ack;
    logic [31:0]    ld_data;
    logic [ASZ-1:0] rom_a;
    logic [7:0]     rom_d;
    logic           busy;

    logic [7:0]     rom_mem [0:ROMSZ-1];
    logic [ASZ-1:0] a_seen  [0:31];
    logic           b_seen  [0:31];

    int total = 0;
    int bad   = 0;

    ej32_rom_arb #(.ASZ(ASZ)) dut (
        .clk    (clk),
        .rst    (rst),
        .if_req (if_req),
        .if_addr(if_addr),
        .if_ack (if_ack),
        .if_data(if_data),
        .ld_req (ld_req),
        .ld_addr(ld_addr),
        .ld_sz  (ld_sz),
        .ld_ack (ld_ack),
        .ld_data(ld_data),
        .rom_a  (rom_a),
        .rom_d  (rom_d),
        .busy   (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROM: data for an address appears one cycle after it is presented.
    always @(posedge clk) rom_d <= rom_mem[rom_a];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input bit is_ld, input logic [1:0] sz);
        if (!is_ld) return 1;
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_data(input logic [ASZ-1:0] a, input int n);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < n; k++) begin
            v = (v << 8) | {24'h0, rom_mem[(int'(a) + k) % ROMSZ]};
        end
        return v;
    endfunction

    // Raise one request in the current cycle and wait for its ack (bounded).
    task automatic run_txn(input bit is_ld, input logic [ASZ-1:0] addr, input logic [1:0] sz,
                           output logic [31:0] data, output int lat);
        logic [7:0]  if_prev;
        logic [31:0] ld_prev;
        bit          got;
        if_prev = if_data;
        ld_prev = ld_data;
        got     = 1'b0;
        lat     = 0;
        data    = 32'hxxxxxxxx;
        if (is_ld) begin
            ld_addr = addr; ld_sz = sz; ld_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        for (int c = 1; c <= 20 && !got; c++) begin
            @(posedge clk);
            @(negedge clk);
            a_seen[c] = rom_a;
            b_seen[c] = busy;
            if (is_ld ? ld_ack : if_ack) begin
                got  = 1'b1;
                lat  = c;
                data = is_ld ? ld_data : {24'h0, if_data};
                chk("other_ack", {31'h0, is_ld ? if_ack : ld_ack}, 32'h0);
                ld_req = 1'b0;
                if_req = 1'b0;
            end
        end
        if (!got) chk("ack_timeout", 32'h0, 32'h1);
        if (is_ld) chk("if_data_hold", {24'h0, if_data}, {24'h0, if_prev});
        else       chk("ld_data_hold", ld_data, ld_prev);
        @(posedge clk);
        @(negedge clk);
        chk("busy_after", {31'h0, busy}, 32'h0);
    endtask

    // Both requests rise in the same cycle; each is dropped when its own ack is seen.
    task automatic run_pair(input logic [ASZ-1:0] ia, input logic [ASZ-1:0] la,
                            input logic [1:0] lsz, input int exp_if_lat, input int exp_ld_lat);
        int il, ll;
        il = 0;
        ll = 0;
        if_addr = ia; ld_addr = la; ld_sz = lsz;
        if_req = 1'b1; ld_req = 1'b1;
        for (int c = 1; c <= 40 && (il == 0 || ll == 0); c++) begin
            @(posedge clk);
            @(negedge clk);
            if (if_ack) begin
                il = c;
                chk("pair_if_data", {24'h0, if_data}, model_data(ia, 1));
                if_req = 1'b0;
            end
            if (ld_ack) begin
                ll = c;
                chk("pair_ld_data", ld_data, model_data(la, nbytes(1'b1, lsz)));
                ld_req = 1'b0;
            end
        end
        chk("pair_if_lat", il, exp_if_lat);
        chk("pair_ld_lat", ll, exp_ld_lat);
        if_req = 1'b0; ld_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit             is_ld;
        logic [ASZ-1:0] addr;
        logic [1:0]     sz;
        logic [31:0]    exp;
        int             lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [31:0]    d;
        int             lat;
        int             n;
        bit             rl;
        logic [ASZ-1:0] ra;
        logic [1:0]     rs;
        int             ack_at;
        bit             early;

        vecs[0] = '{1'b0, 17'h00010, 2'b00, 32'h000000B2, 3};
        vecs[1] = '{1'b1, 17'h00100, 2'b10, 32'h12345678, 6};
        vecs[2] = '{1'b1, 17'h00100, 2'b00, 32'h00000012, 3};
        vecs[3] = '{1'b1, 17'h00100, 2'b01, 32'h00001234, 4};
        vecs[4] = '{1'b1, 17'h00100, 2'b11, 32'h12345678, 6};
        vecs[5] = '{1'b1, 17'h1FFFF, 2'b01, 32'h0000ABCD, 4};
        vecs[6] = '{1'b0, 17'h1FFFF, 2'b00, 32'h000000AB, 3};

        for (int i = 0; i < ROMSZ; i++) rom_mem[i] = 8'($urandom);
        rom_mem[17'h00010] = 8'hB2;
        rom_mem[17'h00100] = 8'h12;
        rom_mem[17'h00101] = 8'h34;
        rom_mem[17'h00102] = 8'h56;
        rom_mem[17'h00103] = 8'h78;
        rom_mem[17'h1FFFF] = 8'hAB;
        rom_mem[17'h00000] = 8'hCD;

        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ld_req = 1'b0; ld_addr = '0; ld_sz = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_busy",    {31'h0, busy},   32'h0);
        chk("rst_if_ack",  {31'h0, if_ack}, 32'h0);
        chk("rst_ld_ack",  {31'h0, ld_ack}, 32'h0);
        chk("rst_if_data", {24'h0, if_data}, 32'h0);
        chk("rst_ld_data", ld_data, 32'h0);
        chk("rst_rom_a",   {15'h0, rom_a},  32'h0);
        rst = 1'b1;
        @(negedge clk);

        // First conflict after reset goes to load, fetch follows after DONE+IDLE.
        run_pair(17'h00010, 17'h00100, 2'b10, 10, 6);
        run_txn(1'b1, 17'h00100, 2'b01, d, lat);
        chk("solo_ld_data", d, 32'h00001234);
        // Load was granted last, so this conflict goes to fetch.
        run_pair(17'h00010, 17'h00100, 2'b10, 3, 10);

        for (int v = 0; v < 7; v++) begin
            run_txn(vecs[v].is_ld, vecs[v].addr, vecs[v].sz, d, lat);
            n = nbytes(vecs[v].is_ld, vecs[v].sz);
            chk($sformatf("vec%0d_data", v), d, vecs[v].exp);
            chk($sformatf("vec%0d_lat", v), lat, vecs[v].lat);
            chk($sformatf("vec%0d_busy1", v), {31'h0, b_seen[1]}, 32'h1);
            for (int k = 0; k < n; k++) begin
                chk($sformatf("vec%0d_rom_a%0d", v, k), {15'h0, a_seen[k + 1]},
                    32'((int'(vecs[v].addr) + k) % ROMSZ));
            end
        end

        for (int r = 0; r < 40; r++) begin
            rl = 1'($urandom_range(0, 1));
            ra = ASZ'($urandom);
            rs = 2'($urandom_range(0, 3));
            run_txn(rl, ra, rs, d, lat);
            n = nbytes(rl, rs);
            chk($sformatf("rnd%0d_data", r), d, model_data(ra, n));
            chk($sformatf("rnd%0d_lat", r), lat, n + 2);
        end

        // Abort a word load during RD; the still-high request is served afresh.
        ld_addr = 17'h00100; ld_sz = 2'b10; ld_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy",    {31'h0, busy},   32'h0);
        chk("abort_if_ack",  {31'h0, if_ack}, 32'h0);
        chk("abort_ld_ack",  {31'h0, ld_ack}, 32'h0);
        chk("abort_if_data", {24'h0, if_data}, 32'h0);
        chk("abort_ld_data", ld_data, 32'h0);
        chk("abort_rom_a",   {15'h0, rom_a},  32'h0);
        @(negedge clk);
        rst = 1'b1;
        ack_at = 0;
        early  = 1'b0;
        for (int c = 1; c <= 20 && ack_at == 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (if_ack) early = 1'b1;
            if (ld_ack) begin
                ack_at = c;
                chk("abort_retry_data", ld_data, 32'h12345678);
                ld_req = 1'b0;
            end
        end
        chk("abort_retry_lat", ack_at, 6);
        chk("abort_no_if_ack", {31'h0, early}, 32'h0);
        @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
